uart_rx_packet_checker: RTL and testbench

//   Downstream consumer of a UART receive port's 11-bit packet (rx_serial1/rx_serial2).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_packet_checker.sv | 101 ++++++++++
 tb/tb_uart_rx_packet_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: 11-bit packet bit positions and the parity helper
// used by both the receive checker and the transmitter.
package uart_pkg;

  localparam int PKT_W      = 11;
  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;

  function automatic logic uart_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received payload bytes; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = LW'(level_q + 1'b1);
      2'b01:   level_d = LW'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of reset; dout masks it while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_packet_checker.sv
// Registers strobed UART packets, checks start/stop/parity, queues good bytes
// and keeps saturating error counters for dropped packets.
module uart_rx_packet_checker
  import uart_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PKT_W-1:0]         pkt_in,
  input  logic                     pkt_strobe,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         err_frame,
  output logic [CNT_W-1:0]         err_parity,
  output logic [CNT_W-1:0]         err_ovf,
  input  logic                     err_clear
);

  localparam logic PAR_SEL = 1'(PARITY_ODD);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  logic [PKT_W-1:0] pkt_p1_q;
  logic             vld_p1_q, vld_p1_d;
  logic             frame_bad, par_bad, good, pop, push, ovf;
  logic             fifo_empty;
  logic [CNT_W-1:0] err_frame_q, err_frame_d;
  logic [CNT_W-1:0] err_parity_q, err_parity_d;
  logic [CNT_W-1:0] err_ovf_q, err_ovf_d;

  // S1: capture the strobed packet
  assign vld_p1_d = pkt_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (pkt_strobe) pkt_p1_q <= pkt_in;
  end

  // S2: check the registered packet and write the FIFO
  assign frame_bad = pkt_p1_q[START_BIT] | ~pkt_p1_q[STOP_BIT];
  assign par_bad   = (uart_parity(pkt_p1_q[DATA_MSB:DATA_LSB]) ^ pkt_p1_q[PARITY_BIT]) != PAR_SEL;
  assign good      = vld_p1_q & ~frame_bad & ~par_bad;
  assign pop       = data_valid & data_ready;
  assign push      = good & (~fifo_full | pop);
  assign ovf       = good & fifo_full & ~pop;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pkt_p1_q[DATA_MSB:DATA_LSB]),
    .dout  (data_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign data_valid = ~fifo_empty;

  // Clear wins over a same-cycle increment.
  always_comb begin
    err_frame_d  = err_clear ? '0 : sat_inc(err_frame_q,  vld_p1_q & frame_bad);
    err_parity_d = err_clear ? '0 : sat_inc(err_parity_q, vld_p1_q & ~frame_bad & par_bad);
    err_ovf_d    = err_clear ? '0 : sat_inc(err_ovf_q,    ovf);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_frame_q  <= '0;
      err_parity_q <= '0;
      err_ovf_q    <= '0;
    end else begin
      err_frame_q  <= err_frame_d;
      err_parity_q <= err_parity_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign err_frame  = err_frame_q;
  assign err_parity = err_parity_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_uart_rx_packet_checker.sv
// Directed bench for uart_rx_packet_checker with hand-computed expectations.
module tb_uart_rx_packet_checker;

  logic        clk;
  logic        reset;
  logic [10:0] pkt_in;
  logic        pkt_strobe;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        fifo_full;
  logic [3:0]  fifo_level;
  logic [7:0]  err_frame, err_parity, err_ovf;
  logic        err_clear;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_packet_checker #(.DEPTH(8), .PARITY_ODD(0), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_in     (pkt_in),
    .pkt_strobe (pkt_strobe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .err_frame  (err_frame),
    .err_parity (err_parity),
    .err_ovf    (err_ovf),
    .err_clear  (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkpkt(input logic stop, input logic par,
                                        input logic [7:0] d, input logic start);
    return {stop, par, d, start};
  endfunction

  // Even-parity good packet: parity bit equals XOR of the data bits.
  function automatic logic [10:0] goodpkt(input logic [7:0] d);
    return mkpkt(1'b1, ^d, d, 1'b0);
  endfunction

  task automatic send(input logic [10:0] p);
    pkt_in     = p;
    pkt_strobe = 1'b1;
    tick();
    pkt_strobe = 1'b0;
  endtask

  logic [7:0] exp_b;

  initial begin
    reset      = 1'b1;
    pkt_in     = '0;
    pkt_strobe = 1'b0;
    data_ready = 1'b0;
    err_clear  = 1'b0;
    tick();
    tick();
    chk("rst_valid", data_valid, 0);
    chk("rst_full",  fifo_full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_dout",  data_out, 0);
    chk("rst_cnts",  {err_frame, err_parity, err_ovf}, 0);
    reset = 1'b0;
    tick();

    // 1: good packet, 2-cycle latency
    send(mkpkt(1'b1, 1'b0, 8'hA5, 1'b0));
    chk("t1_lat1_valid", data_valid, 0);
    tick();
    chk("t1_valid", data_valid, 1);
    chk("t1_dout",  data_out, 8'hA5);
    chk("t1_level", fifo_level, 1);
    chk("t1_cnts",  {err_frame, err_parity, err_ovf}, 0);
    data_ready = 1'b1;
    tick();
    chk("t1_pop_valid", data_valid, 0);
    tick();
    chk("pop_empty_level", fifo_level, 0);
    data_ready = 1'b0;

    // 2: parity error
    send(mkpkt(1'b1, 1'b1, 8'hA5, 1'b0));
    tick();
    chk("t2_valid",  data_valid, 0);
    chk("t2_par",    err_parity, 1);
    chk("t2_frame",  err_frame, 0);

    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_par", err_parity, 0);

    // 3: frame error with bad parity counts only as frame
    send(mkpkt(1'b0, 1'b1, 8'hA5, 1'b0));
    tick();
    chk("t3_valid", data_valid, 0);
    chk("t3_frame", err_frame, 1);
    chk("t3_par",   err_parity, 0);

    // 4: overflow with back-to-back strobes
    for (int i = 1; i <= 10; i++) begin
      pkt_in     = goodpkt(8'(i));
      pkt_strobe = 1'b1;
      tick();
    end
    pkt_strobe = 1'b0;
    tick();
    chk("t4_full",  fifo_full, 1);
    chk("t4_level", fifo_level, 8);
    chk("t4_ovf",   err_ovf, 2);
    chk("t4_head",  data_out, 8'h01);

    // 5: push into full FIFO alongside a pop
    send(goodpkt(8'h55));
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("t5_level", fifo_level, 8);
    chk("t5_full",  fifo_full, 1);
    chk("t5_ovf",   err_ovf, 2);
    chk("t5_head",  data_out, 8'h02);
    tick();
    chk("t5_stable", data_out, 8'h02);
    data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(i + 2) : 8'h55;
      chk("t5_drain", data_out, exp_b);
      tick();
    end
    data_ready = 1'b0;
    chk("t5_empty", data_valid, 0);

    // 6: reset between strobe and its check cycle
    send(goodpkt(8'h11));
    tick();
    chk("t6_pre_valid", data_valid, 1);
    send(goodpkt(8'h3C));
    reset = 1'b1;
    #2;
    chk("t6_rst_valid", data_valid, 0);
    chk("t6_rst_level", fifo_level, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("t6_no_stale", data_valid, 0);
    chk("t6_level",    fifo_level, 0);
    chk("t6_ovf",      err_ovf, 0);

    for (int i = 0; i < 257; i++) begin
      pkt_in     = mkpkt(1'b0, 1'b0, 8'h00, 1'b0);
      pkt_strobe = 1'b1;
      tick();
    end
    pkt_strobe = 1'b0;
    tick();
    chk("t6_sat", err_frame, 255);
    send(mkpkt(1'b1, 1'b0, 8'h00, 1'b1));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t6_clr_prio", err_frame, 0);
    tick();
    chk("t6_clr_hold", err_frame, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
